seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial bit-pattern detector with a runtime-programmable pattern, pattern length and overlap mode. Each cycle it samples one qualified input bit and raises a registered Moore-style one-cycle `dout` pulse when the most recent bits match the programmed pattern. A saturating match counter runs alongside the detector. The block is the general successor to the team's fixed-pattern `10110` overlapping detectors and serves any serial-stream framing/sync-word function.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits (≥2).
- `CNT_W`, 8: width of the match counter.
- `DEF_PATTERN`, 16'b10110 (zero-extended to `MAX_LEN`): pattern loaded at reset.
- `DEF_LEN`, 5: pattern length loaded at reset.
- `DEF_OVERLAP`, 1: overlap mode loaded at reset.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in 1: serial data bit.
- `din_valid` in 1: `din` is sampled only when high.
- `cfg_load` in 1: one-cycle pulse that latches `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern` in `MAX_LEN`: pattern; bit `[len-1]` is the first bit received and bit `[0]` is the last.
- `cfg_len` in `$clog2(MAX_LEN+1)`: pattern length.
- `cfg_overlap` in 1: 1 = overlapping detection; 0 = non-overlapping.
- `cnt_clr` in 1: clears the match counter.
- `dout` out 1: registered match pulse.
- `match_count` out `CNT_W`: saturating count of matches.
- `cfg_err` out 1: the active configuration is invalid.

## Operation
- **History register.** `hist[MAX_LEN-1:0]`. On each valid sample it updates as `hist <= {hist[MAX_LEN-2:0], din}`, so `hist[0]` is always the newest bit.
- **Fill counter.** `fill` counts valid bits received since the last reset, config load or non-overlap match. It saturates at `MAX_LEN`.
- **Match condition.** Evaluated combinationally on the sampling edge, including the incoming bit: `din_valid & ~cfg_err & (fill+1 ≥ len) & ({hist,din}[len-1:0] == pattern[len-1:0])`.
- **Overlap = 1.** `fill` continues to increment and saturate after a match, so the tail of one match can begin the next.
- **Overlap = 0.** On a match, `fill` is forced to 0. `hist` still shifts, but the bits already consumed cannot contribute to a new match.
- **Configuration load.**
  - `cfg_load` copies the three config inputs into active registers.
  - It clears `hist` and `fill`.
  - It sets `cfg_err = (cfg_len == 0) | (cfg_len > MAX_LEN)`.
  - While `cfg_err` = 1, no match ever fires. The counter holds its value.
- **Match counter.** `match_count` increments on each match and saturates at `2^CNT_W - 1`; it never wraps.
- **Reset.**
  - Active config is loaded from the `DEF_*` parameters.
  - `hist`, `fill`, `dout`, `match_count` and `cfg_err` all reset to 0.
- **Precedence (highest first).**
  - `rst` overrides everything.
  - `cfg_load` overrides `din_valid`: the bit presented in that cycle is discarded and `dout` is 0 next cycle.
  - `cnt_clr` overrides a same-cycle increment: the counter goes to 0, but `dout` still pulses.
- **Mid-stream changes.** Reset or `cfg_load` in the middle of a partial pattern discards all partial progress. No match can straddle either event.

## Timing
- **Match latency.** `dout` goes high in the cycle immediately after the edge that samples the completing bit. It is high for exactly one cycle.
- **`dout` deassertion.** `dout` is 0 in any cycle that follows an edge with no match, including edges where `din_valid` = 0.
- **Counter timing.** `match_count` updates on the same edge that sets `dout`.
- **Config timing.** The new config and `cfg_err` are visible the cycle after `cfg_load`. The first bit that can use the new config is the one sampled on the following edge.
- **Minimum match spacing.**
  - Overlap mode: matches can occur on consecutive valid samples (1 cycle apart, e.g. pattern `11`, len 2, input `111`).
  - Non-overlap mode: matches are at least `len` valid samples apart.
- **Gaps in `din_valid`.** A gap freezes `hist` and `fill`. A pattern split by gaps still matches.

## Test plan
- **Reset default, overlap.** After `rst`, send `din` = 1,0,1,1,0,1,1,0 with `din_valid` continuously high. Required: `dout` pulses after the 5th and 8th bits, and `match_count` = 2.
- **Non-overlap.** `cfg_load` with pattern 10110, len 5, overlap 0, then send the same 8 bits. Required: a single pulse after the 5th bit, and `match_count` = 1.
- **Valid gaps and reset mid-pattern.**
  - Send 1,0,1 with `din_valid` low for 3 cycles between bits, then 1,0. Required: a pulse after the final bit.
  - Send 1,0,1,1, assert `rst`, then send 0. Required: no pulse.
- **Config edge cases.**
  - `cfg_load` with len 0. Required: `cfg_err` = 1 and no pulses on any stream.
  - `cfg_load` with len = `MAX_LEN` and an all-ones pattern, then send `MAX_LEN`+1 ones in overlap mode. Required: pulses after bit `MAX_LEN` and bit `MAX_LEN`+1.
- **Counter saturation and precedence.**
  - With `CNT_W` = 2, generate 5 matches. Required: `match_count` stops at 3.
  - Assert `cnt_clr` together with a completing bit. Required: `match_count` = 0 and `dout` = 1.
- **Load during data.** Assert `cfg_load` in the same cycle as the completing 5th bit of 10110. Required: the bit is discarded, no pulse, and `hist`/`fill` restart from empty.

Source files
------------

// File: rtl/seq_detect_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Serial bit-pattern detector with a runtime-programmable pattern, pattern
// length and overlap mode. One qualified bit is sampled per cycle. A one-cycle
// registered pulse on dout follows the edge that samples the completing bit.
// A saturating match counter runs alongside the detector.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset (loads DEF_* config)
//   din          in   serial data bit
//   din_valid    in   din is sampled only when high
//   cfg_load     in   latch cfg_pattern / cfg_len / cfg_overlap, flush history
//   cfg_pattern  in   pattern, bit [len-1] is the first bit received
//   cfg_len      in   pattern length (valid range 1..MAX_LEN)
//   cfg_overlap  in   1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      in   clear the match counter (wins over an increment)
//   dout         out  registered match pulse
//   match_count  out  saturating match count
//   cfg_err      out  active configuration is invalid (no matches fire)
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter int                 MAX_LEN     = 16,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(5'b10110),
  parameter int                 DEF_LEN     = 5,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din,
  input  logic                           din_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           dout,
  output logic [CNT_W-1:0]               match_count,
  output logic                           cfg_err
);

  localparam int                LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]  DEF_LEN_L = LEN_W'(DEF_LEN);
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Active configuration
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               err_q, err_d;

  // Only MAX_LEN-1 history bits are kept: together with the incoming bit they
  // form the full MAX_LEN compare window, and anything older can never be
  // part of a match.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Compare window: newest bit (the one being sampled) in position 0.
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               pattern_hit;
  logic               fill_ok;
  logic               match;
  logic [LEN_W-1:0]   fill_inc;

  assign window = {hist_q, din};

  // Select only the low len bits of window/pattern for the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_q);
  end

  assign pattern_hit = (((window ^ pattern_q) & len_mask) == '0);

  // fill counts bits already held; the incoming bit makes it fill+1.
  assign fill_ok = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);

  // A load in the same cycle discards the incoming bit entirely.
  assign match = din_valid & ~cfg_load & ~err_q & fill_ok & pattern_hit;

  assign fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + 1'b1;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    err_d     = err_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    dout_d    = 1'b0;
    cnt_d     = cnt_q;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      err_d     = (cfg_len == '0) | (cfg_len > MAX_LEN_L);
      hist_d    = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      hist_d = window[MAX_LEN-2:0];
      if (match) begin
        dout_d = 1'b1;
        // Non-overlap: bits consumed by this match may not start another.
        fill_d = overlap_q ? fill_inc : '0;
      end else begin
        fill_d = fill_inc;
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= DEF_LEN_L;
      overlap_q <= DEF_OVERLAP;
      err_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      dout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      err_q     <= err_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dout        = dout_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule
